// File: rtl/nf_pktgen_mf_pkg.sv
// Shared types and constants for the multi-flow packet generator.
package nf_pktgen_mf_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam int          MIN_LEN = 60;
   localparam int          MAX_LEN = 9600;
   localparam logic [23:0] MAGIC   = 24'h5AA5C3;
endpackage

// File: rtl/nf_pktgen_seq_table.sv
// Per-flow sequence counters: bulk clear, increment by index, combinational read.
module nf_pktgen_seq_table #(
   parameter int NUM_FLOWS = 4,
   parameter int CNT_W     = 32
) (
   input  logic             clk156,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             inc,
   input  logic [7:0]       inc_idx,
   input  logic [7:0]       rd_idx,
   output logic [CNT_W-1:0] rd_data
);
   logic [NUM_FLOWS-1:0][CNT_W-1:0] seq_q;

   always_ff @(posedge clk156 or negedge reset_n) begin
      if (!reset_n) begin
         seq_q <= '0;
      end else if (clr) begin
         seq_q <= '0;
      end else if (inc) begin
         for (int f = 0; f < NUM_FLOWS; f++)
            if (inc_idx == 8'(f)) seq_q[f] <= seq_q[f] + 1'b1;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int f = 0; f < NUM_FLOWS; f++)
         if (rd_idx == 8'(f)) rd_data = seq_q[f];
   end
endmodule

// File: rtl/nf_pktgen_mf.sv
// Multi-flow AXI-Stream frame generator: round-robin flows, per-flow sequence numbers, IFG.
module nf_pktgen_mf
   import nf_pktgen_mf_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH/8,
   parameter int NUM_FLOWS  = 4,
   parameter int LEN_W      = 14,
   parameter int CNT_W      = 32
) (
   input  logic                  clk156,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic [LEN_W-1:0]      cfg_len,
   input  logic [15:0]           cfg_ifg,
   input  logic [CNT_W-1:0]      cfg_count,
   input  logic [7:0]            cfg_flows,
   output logic                  s_axis_tx_tvalid,
   input  logic                  s_axis_tx_tready,
   output logic [DATA_WIDTH-1:0] s_axis_tx_tdata,
   output logic [KEEP_WIDTH-1:0] s_axis_tx_tkeep,
   output logic                  s_axis_tx_tlast,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_W-1:0]      frames_sent
);
   localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

   state_t                  state_q, state_d;
   logic [LEN_W-1:0]        beats_q, beat_q;
   logic [KEEP_WIDTH-1:0]   lkeep_q;
   logic [15:0]             ifg_q, gap_q;
   logic [CNT_W-1:0]        count_q;
   logic [8:0]              flows_q;
   logic [7:0]              flow_ptr;
   logic                    stop_pend;

   // Config as it would be latched by a start this cycle.
   logic [LEN_W-1:0]        len_c, beats_c;
   logic [31:0]             rem_c;
   logic [KEEP_WIDTH-1:0]   lkeep_c;
   logic [8:0]              flows_c;

   always_comb begin
      len_c   = (cfg_len < MIN_L) ? MIN_L : (cfg_len > MAX_L) ? MAX_L : cfg_len;
      beats_c = LEN_W'((32'(len_c) + KEEP_WIDTH - 1) / KEEP_WIDTH);
      rem_c   = 32'(len_c) % KEEP_WIDTH;
      for (int i = 0; i < KEEP_WIDTH; i++)
         lkeep_c[i] = (rem_c == 0) || (32'(i) < rem_c);
      flows_c = (cfg_flows == 8'd0) ? 9'd1 :
                ({1'b0, cfg_flows} > 9'(NUM_FLOWS)) ? 9'(NUM_FLOWS) : {1'b0, cfg_flows};
   end

   logic                    idle_start, hs, fin, ld, drop;
   logic [LEN_W-1:0]        ld_k, beats_u;
   logic [KEEP_WIDTH-1:0]   lkeep_u;
   logic [7:0]              ld_flow, flow_adv, rd_idx;
   logic [8:0]              fp1;
   logic [CNT_W-1:0]        ld_seq, seq_rd, frames_inc;
   logic                    last_frame;

   assign idle_start = (state_q == ST_IDLE) && start;
   assign hs         = s_axis_tx_tvalid && s_axis_tx_tready;
   assign fp1        = {1'b0, flow_ptr} + 9'd1;
   assign flow_adv   = (fp1 >= flows_q) ? 8'd0 : fp1[7:0];
   assign frames_inc = frames_sent + 1'b1;
   assign last_frame = (count_q != '0) && (frames_inc == count_q);
   assign beats_u    = (state_q == ST_IDLE) ? beats_c : beats_q;
   assign lkeep_u    = (state_q == ST_IDLE) ? lkeep_c : lkeep_q;

   nf_pktgen_seq_table #(.NUM_FLOWS(NUM_FLOWS), .CNT_W(CNT_W)) u_seq (
      .clk156  (clk156),
      .reset_n (reset_n),
      .clr     (idle_start),
      .inc     (fin),
      .inc_idx (flow_ptr),
      .rd_idx  (rd_idx),
      .rd_data (seq_rd)
   );

   always_comb begin
      state_d = state_q;
      ld      = 1'b0;
      drop    = 1'b0;
      fin     = 1'b0;
      ld_k    = '0;
      ld_flow = flow_ptr;
      rd_idx  = flow_ptr;
      ld_seq  = seq_rd;
      case (state_q)
         ST_IDLE: if (start) begin
            state_d = ST_SEND;
            ld      = 1'b1;
            ld_flow = 8'd0;
            ld_seq  = '0;
         end
         ST_SEND: if (hs) begin
            if (!s_axis_tx_tlast) begin
               ld   = 1'b1;
               ld_k = beat_q + 1'b1;
            end else begin
               fin     = 1'b1;
               rd_idx  = flow_adv;
               ld_flow = flow_adv;
               // Single active flow: its counter increments on this same edge.
               ld_seq  = seq_rd + CNT_W'(flow_adv == flow_ptr);
               if (stop_pend || stop || last_frame) begin
                  state_d = ST_IDLE;
                  drop    = 1'b1;
               end else if (ifg_q != 16'd0) begin
                  state_d = ST_GAP;
                  drop    = 1'b1;
               end else begin
                  ld = 1'b1;
               end
            end
         end
         ST_GAP: if (stop) begin
            state_d = ST_IDLE;
            drop    = 1'b1;
         end else if (gap_q == 16'd1) begin
            state_d = ST_SEND;
            ld      = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   function automatic logic [DATA_WIDTH-1:0] fmt_beat(logic [LEN_W-1:0] k,
                                                      logic [CNT_W-1:0] seq,
                                                      logic [7:0] flow);
      logic [DATA_WIDTH-1:0] d;
      if (k == '0) begin
         d       = '0;
         d[63:0] = {MAGIC, flow, 32'(seq)};
      end else begin
         d = {KEEP_WIDTH{k[7:0]}};
      end
      return d;
   endfunction

   always_ff @(posedge clk156 or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         beats_q          <= '0;
         beat_q           <= '0;
         lkeep_q          <= '0;
         ifg_q            <= '0;
         gap_q            <= '0;
         count_q          <= '0;
         flows_q          <= 9'd1;
         flow_ptr         <= '0;
         stop_pend        <= 1'b0;
         frames_sent      <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         s_axis_tx_tvalid <= 1'b0;
         s_axis_tx_tdata  <= '0;
         s_axis_tx_tkeep  <= '0;
         s_axis_tx_tlast  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (idle_start) begin
            beats_q     <= beats_c;
            lkeep_q     <= lkeep_c;
            ifg_q       <= cfg_ifg;
            count_q     <= cfg_count;
            flows_q     <= flows_c;
            flow_ptr    <= '0;
            frames_sent <= '0;
            stop_pend   <= 1'b0;
         end else if (stop && state_q != ST_IDLE) begin
            stop_pend <= 1'b1;
         end
         if (fin) begin
            frames_sent <= frames_inc;
            flow_ptr    <= flow_adv;
         end
         if (state_d == ST_IDLE && state_q != ST_IDLE) begin
            done      <= 1'b1;
            stop_pend <= 1'b0;
         end
         if (state_q == ST_SEND && state_d == ST_GAP) gap_q <= ifg_q;
         else if (state_q == ST_GAP)                   gap_q <= gap_q - 1'b1;
         if (ld) begin
            s_axis_tx_tvalid <= 1'b1;
            s_axis_tx_tdata  <= fmt_beat(ld_k, ld_seq, ld_flow);
            s_axis_tx_tlast  <= (ld_k == beats_u - 1'b1);
            s_axis_tx_tkeep  <= (ld_k == beats_u - 1'b1) ? lkeep_u : '1;
            beat_q           <= ld_k;
         end else if (drop) begin
            s_axis_tx_tvalid <= 1'b0;
            s_axis_tx_tdata  <= '0;
            s_axis_tx_tkeep  <= '0;
            s_axis_tx_tlast  <= 1'b0;
         end
         busy    <= (state_d != ST_IDLE);
         state_q <= state_d;
      end
   end
endmodule
